reverb_out_limiter: RTL and testbench

Output peak limiter that sits directly downstream of the Reverb stage and consumes its 16-bit signed wet output before the sample is written out or sent to the DAC. It applies a time-varying Q1.15 gain driven by an attack/hold/release state machine. A final hard clamp guarantees that no output sample exceeds a runtime threshold. One sample is processed per in_valid strobe, with a fixed two-cycle latency.

---
 rtl/reverb_out_limiter.sv | 167 ++++++++++++++++
 tb/tb_reverb_out_limiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reverb_out_limiter.sv
// Output peak limiter behind the reverb: attack/hold/release Q1.15 gain plus a
// hard clamp at a runtime threshold, two-cycle latency per valid sample.
module reverb_out_limiter #(
   parameter int          ATTACK_SHIFT  = 2,
   parameter int          RELEASE_SHIFT = 8,
   parameter int          HOLD_SAMPLES  = 256,
   parameter logic [15:0] GAIN_MIN      = 16'h0400
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [15:0] limiter_data_in,
   input  logic [14:0] threshold,
   input  logic        bypass,
   output logic        out_valid,
   output logic [15:0] limiter_data_out,
   output logic [15:0] gain_out,
   output logic        clip_flag,
   output logic [1:0]  fsm_state
);
   typedef enum logic [1:0] {IDLE = 2'd0, ATTACK = 2'd1, HOLD = 2'd2, RELEASE = 2'd3} state_t;

   localparam logic [15:0] UNITY = 16'h7FFF;
   localparam int HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_SAMPLES - 1);

   state_t        state_q, state_d;
   logic [15:0]   g_q, g_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [15:0]   x_q, gu_q;
   logic [14:0]   th_q;
   logic          bp_q, v1_q;
   logic          ov_q, clip_q, clip_d;
   logic [15:0]   out_q, out_d;

   // Stage 1: magnitude after gain (drives the envelope decision) and gain steps.
   logic [14:0] a_mag;
   logic [31:0] m_prod;
   logic [15:0] m_val, g_dec_raw, g_dec, g_step, g_inc;
   logic [16:0] g_sum;
   logic        over;

   always_comb begin
      if (limiter_data_in == 16'h8000)
         a_mag = 15'h7FFF;
      else if (limiter_data_in[15])
         a_mag = 15'(16'd0 - limiter_data_in);
      else
         a_mag = limiter_data_in[14:0];
      m_prod    = {17'd0, a_mag} * {16'd0, g_q};
      m_val     = (g_q == UNITY) ? {1'b0, a_mag} : 16'((m_prod + 32'h0000_4000) >> 15);
      over      = m_val > {1'b0, threshold};
      g_dec_raw = g_q - (g_q >> ATTACK_SHIFT);
      g_dec     = (g_dec_raw < GAIN_MIN) ? GAIN_MIN : g_dec_raw;
      g_step    = ((UNITY - g_q) >> RELEASE_SHIFT) + 16'd1;
      g_sum     = {1'b0, g_q} + {1'b0, g_step};
      g_inc     = (g_sum > {1'b0, UNITY}) ? UNITY : g_sum[15:0];
   end

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      hold_d  = hold_q;
      if (bypass) begin
         state_d = IDLE;
         g_d     = UNITY;
      end else if (in_valid) begin
         case (state_q)
            IDLE: begin
               g_d = UNITY;
               if (over) begin
                  g_d     = g_dec;
                  state_d = ATTACK;
               end
            end
            ATTACK: begin
               if (over) begin
                  g_d = g_dec;
               end else begin
                  state_d = HOLD;
                  hold_d  = HOLD_LOAD;
               end
            end
            HOLD: begin
               if (over) begin
                  g_d     = g_dec;
                  state_d = ATTACK;
               end else if (hold_q == '0) begin
                  state_d = RELEASE;
               end else begin
                  hold_d = hold_q - HW'(1);
               end
            end
            RELEASE: begin
               if (over) begin
                  g_d     = g_dec;
                  state_d = ATTACK;
               end else begin
                  g_d = g_inc;
                  if (g_inc == UNITY) state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Stage 2: scale by the gain that was in effect before this sample's update, then clamp.
   logic signed [31:0] y_prod;
   logic signed [17:0] y_val, th_pos, th_neg;

   always_comb begin
      y_prod = $signed(x_q) * $signed(gu_q);
      y_val  = (gu_q == UNITY) ? 18'($signed(x_q)) : 18'((y_prod + 32'sd16384) >>> 15);
      th_pos = $signed({3'b000, th_q});
      th_neg = -th_pos;
      out_d  = y_val[15:0];
      clip_d = 1'b0;
      if (bp_q) begin
         out_d = x_q;
      end else if (y_val > th_pos) begin
         out_d  = th_pos[15:0];
         clip_d = 1'b1;
      end else if (y_val < th_neg) begin
         out_d  = th_neg[15:0];
         clip_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         g_q     <= UNITY;
         hold_q  <= '0;
         x_q     <= '0;
         gu_q    <= UNITY;
         th_q    <= '0;
         bp_q    <= 1'b0;
         v1_q    <= 1'b0;
         ov_q    <= 1'b0;
         out_q   <= '0;
         clip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         hold_q  <= hold_d;
         v1_q    <= in_valid;
         ov_q    <= v1_q;
         if (in_valid) begin
            x_q  <= limiter_data_in;
            gu_q <= g_q;
            th_q <= threshold;
            bp_q <= bypass;
         end
         if (v1_q) begin
            out_q  <= out_d;
            clip_q <= clip_d;
         end
      end
   end

   assign out_valid        = ov_q;
   assign limiter_data_out = out_q;
   assign clip_flag        = clip_q;
   assign gain_out         = g_q;
   assign fsm_state        = state_q;
endmodule

// File: tb/tb_reverb_out_limiter.sv
// Bench for reverb_out_limiter: directed envelope scenarios plus random traffic,
// checked every cycle against an arithmetic reference of the limiter rules.
module tb_reverb_out_limiter;
   localparam int A_SH   = 2;
   localparam int R_SH   = 8;
   localparam int HOLD_N = 4;
   localparam int G_MIN  = 1024;
   localparam int UNITY  = 32767;
   localparam int M_IDLE = 0, M_ATTACK = 1, M_HOLD = 2, M_RELEASE = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] limiter_data_in;
   logic [14:0] threshold;
   logic        bypass;
   logic        out_valid;
   logic [15:0] limiter_data_out;
   logic [15:0] gain_out;
   logic        clip_flag;
   logic [1:0]  fsm_state;

   always #5 clk = ~clk;

   reverb_out_limiter #(.HOLD_SAMPLES(HOLD_N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .limiter_data_in(limiter_data_in),
      .threshold(threshold), .bypass(bypass), .out_valid(out_valid),
      .limiter_data_out(limiter_data_out), .gain_out(gain_out),
      .clip_flag(clip_flag), .fsm_state(fsm_state)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [16:0] exp_q[$];
   int          mode, mg, mhold;
   bit          vh1, vh2;
   logic [15:0] last_out;
   logic        last_clip;
   int          pt[4] = '{1000, -1000, 24576, -24576};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic void model_reset();
      mode = M_IDLE; mg = UNITY; mhold = 0;
      exp_q.delete();
      vh1 = 1'b0; vh2 = 1'b0;
      last_out = '0; last_clip = 1'b0;
   endfunction

   // Reference: envelope follower and clamp, expressed as integer arithmetic.
   function automatic void model_step(input bit v, input logic [15:0] x, input logic [14:0] th, input bit bp);
      int xs, a, m, y, t;
      bit clip;
      if (bp) begin
         mode = M_IDLE; mg = UNITY;
         if (v) exp_q.push_back({1'b0, x});
         return;
      end
      if (!v) return;
      xs = $signed(x);
      t  = int'(th);
      a  = (xs < 0) ? -xs : xs;
      if (a > 32767) a = 32767;
      m = (mg == UNITY) ? a  : (a * mg + 16384) >>> 15;
      y = (mg == UNITY) ? xs : (xs * mg + 16384) >>> 15;
      clip = 1'b1;
      if (y > t) y = t;
      else if (y < -t) y = -t;
      else clip = 1'b0;
      exp_q.push_back({clip, 16'(y)});
      if (m > t) begin
         mg = mg - (mg >> A_SH);
         if (mg < G_MIN) mg = G_MIN;
         mode = M_ATTACK;
      end else begin
         case (mode)
            M_ATTACK: begin mode = M_HOLD; mhold = HOLD_N - 1; end
            M_HOLD: if (mhold == 0) mode = M_RELEASE; else mhold--;
            M_RELEASE: begin
               mg = mg + ((UNITY - mg) >> R_SH) + 1;
               if (mg >= UNITY) begin mg = UNITY; mode = M_IDLE; end
            end
            default: ;
         endcase
      end
   endfunction

   task automatic cycle(input bit v, input logic [15:0] x, input logic [14:0] th, input bit bp);
      logic [16:0] e;
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(vh2));
      if (vh2 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         last_out = e[15:0];
         last_clip = e[16];
      end
      chk("data_out", 32'(limiter_data_out), 32'(last_out));
      chk("clip_flag", 32'(clip_flag), 32'(last_clip));
      chk("gain_out", 32'(gain_out), 32'(mg));
      chk("fsm_state", 32'(fsm_state), 32'(mode));
      in_valid = v; limiter_data_in = x; threshold = th; bypass = bp;
      model_step(v, x, th, bp);
      vh2 = vh1; vh1 = v;
   endtask

   task automatic do_reset_mid();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(limiter_data_out), 32'd0);
      chk("rst_gain", 32'(gain_out), 32'h7FFF);
      chk("rst_clip", 32'(clip_flag), 32'd0);
      chk("rst_state", 32'(fsm_state), 32'(M_IDLE));
      in_valid = 1'b0; bypass = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int amp_sh;
      logic [14:0] rth;
      rst = 1'b1; in_valid = 1'b0; limiter_data_in = '0; threshold = '0; bypass = 1'b0;
      model_reset();
      #1;
      chk("init_out_valid", 32'(out_valid), 32'd0);
      chk("init_gain", 32'(gain_out), 32'h7FFF);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // pass-through below threshold
      for (int i = 0; i < 4; i++) cycle(1'b1, 16'(pt[i]), 15'd24576, 1'b0);
      repeat (2) cycle(1'b0, 16'd0, 15'd24576, 1'b0);

      // attack, hold for 4 samples, release back to unity
      repeat (2) cycle(1'b1, 16'h7FFF, 15'd24576, 1'b0);
      chk("attack_gain_lit", 32'(gain_out), 32'h6000);
      repeat (4) cycle(1'b1, 16'd0, 15'd24576, 1'b0);
      cycle(1'b1, 16'd0, 15'd24576, 1'b0);
      chk("release_state_lit", 32'(fsm_state), 32'(M_RELEASE));
      cycle(1'b0, 16'd0, 15'd24576, 1'b0);
      chk("release_gain_lit", 32'(gain_out), 32'h6020);
      for (int i = 0; i < 3000 && mode != M_IDLE; i++) cycle(1'b1, 16'd0, 15'd24576, 1'b0);
      repeat (2) cycle(1'b0, 16'd0, 15'd24576, 1'b0);
      chk("back_to_unity", 32'(gain_out), 32'h7FFF);

      // re-attack during release
      cycle(1'b1, 16'h7FFF, 15'd24576, 1'b0);
      repeat (15) cycle(1'b1, 16'd0, 15'd24576, 1'b0);
      cycle(1'b1, 16'h7FFF, 15'd24576, 1'b0);
      repeat (2) cycle(1'b0, 16'd0, 15'd24576, 1'b0);

      // bypass asserted mid-attack with extreme inputs
      cycle(1'b1, 16'h7FFF, 15'd24576, 1'b0);
      cycle(1'b1, 16'h8000, 15'd24576, 1'b1);
      cycle(1'b1, 16'h7FFF, 15'd24576, 1'b1);
      cycle(1'b0, 16'd0, 15'd24576, 1'b1);
      repeat (2) cycle(1'b0, 16'd0, 15'd24576, 1'b0);

      // zero threshold
      cycle(1'b1, 16'd1000, 15'd0, 1'b0);
      cycle(1'b1, 16'hFFFB, 15'd0, 1'b0);
      cycle(1'b1, 16'd0, 15'd0, 1'b0);
      for (int i = 0; i < 3000 && mode != M_IDLE; i++) cycle(1'b1, 16'd0, 15'd24576, 1'b0);

      // random traffic
      amp_sh = 0; rth = 15'd20000;
      for (int i = 0; i < 3000; i++) begin
         if (i % 64 == 0) begin
            amp_sh = $urandom_range(0, 8);
            rth = 15'($urandom_range(1, 32767));
         end
         cycle($urandom_range(0, 3) != 0,
               16'($signed(16'($urandom_range(0, 65535))) >>> amp_sh),
               rth, $urandom_range(0, 31) == 0);
      end
      repeat (2) cycle(1'b0, 16'd0, rth, 1'b0);

      // asynchronous reset mid-stream
      repeat (3) cycle(1'b1, 16'h7FFF, 15'd1000, 1'b0);
      do_reset_mid();
      cycle(1'b1, 16'd1234, 15'd24576, 1'b0);
      repeat (3) cycle(1'b0, 16'd0, 15'd24576, 1'b0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
